// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer RAM between VGA scan-out (one-pixel prefetch) and a req/ack pixel writer.
// Read data lands on R/G/B two cycles after its DISP slot; a writer request waits at most one slot and is acked combinationally.
module vga_fb_arbiter #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int FB_W        = 320,
    parameter int FB_H        = 240,
    parameter int SCALE_SHIFT = 1,
    parameter int AW          = 17
) (
    input  logic          FPGA_Clock,
    input  logic          Reset_N,
    input  logic [9:0]    H_COUNT,
    input  logic [9:0]    V_COUNT,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    output logic          wr_ack,
    output logic [AW-1:0] fb_addr,
    output logic          fb_we,
    output logic [7:0]    fb_wdata,
    input  logic [7:0]    fb_rdata,
    output logic [7:0]    R,
    output logic [7:0]    G,
    output logic [7:0]    B,
    output logic          vblank
);

    localparam logic [10:0]   H_ACT     = 11'(H_ACTIVE);
    localparam logic [10:0]   V_ACT     = 11'(V_ACTIVE);
    localparam logic [10:0]   FBW_PIX   = 11'(FB_W);
    localparam logic [10:0]   FBH_PIX   = 11'(FB_H);
    localparam logic [9:0]    H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]    V_ACT_CNT = 10'(V_ACTIVE);
    localparam logic [AW-1:0] ROW_PITCH = AW'(FB_W);

    logic [9:0]    hc_prev;
    logic          disp;
    logic          disp_d;
    logic          rd_pending;
    logic [10:0]   fx;
    logic [10:0]   fy;
    logic [10:0]   fx_fb;
    logic [10:0]   fy_fb;
    logic          fetch_ok;
    logic          rd;
    logic [AW-1:0] fetch_addr;

    assign disp = (H_COUNT != hc_prev);

    // Coordinate of the pixel the raster reaches next, wrapping at line and frame end.
    always_comb begin
        fx = {1'b0, H_COUNT} + 11'd1;
        fy = {1'b0, V_COUNT};
        if (H_COUNT == H_LAST) begin
            fx = '0;
            fy = (V_COUNT == V_LAST) ? 11'd0 : ({1'b0, V_COUNT} + 11'd1);
        end
    end

    assign fx_fb      = fx >> SCALE_SHIFT;
    assign fy_fb      = fy >> SCALE_SHIFT;
    assign fetch_ok   = (fx < H_ACT) && (fy < V_ACT) && (fx_fb < FBW_PIX) && (fy_fb < FBH_PIX);
    assign rd         = disp && fetch_ok;
    assign fetch_addr = AW'(fy_fb) * ROW_PITCH + AW'(fx_fb);

    // Display read owns the DISP slot; every other cycle belongs to the writer.
    always_comb begin
        wr_ack   = 1'b0;
        fb_we    = 1'b0;
        fb_addr  = '0;
        fb_wdata = '0;
        if (Reset_N) begin
            if (rd) begin
                fb_addr = fetch_addr;
            end else if (wr_req) begin
                fb_addr  = wr_addr;
                fb_we    = 1'b1;
                fb_wdata = wr_data;
                wr_ack   = 1'b1;
            end
        end
    end

    always_ff @(posedge FPGA_Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            hc_prev    <= '0;
            disp_d     <= 1'b0;
            rd_pending <= 1'b0;
            vblank     <= 1'b0;
            R          <= '0;
            G          <= '0;
            B          <= '0;
        end else begin
            hc_prev <= H_COUNT;
            disp_d  <= disp;
            vblank  <= (V_COUNT >= V_ACT_CNT);
            if (disp_d) begin
                R <= rd_pending ? {fb_rdata[7:5], fb_rdata[7:5], fb_rdata[7:6]} : 8'd0;
                G <= rd_pending ? {fb_rdata[4:2], fb_rdata[4:2], fb_rdata[4:3]} : 8'd0;
                B <= rd_pending ? {4{fb_rdata[1:0]}} : 8'd0;
            end
            // A new read issued back-to-back with a load must survive the clear.
            if (rd) begin
                rd_pending <= 1'b1;
            end else if (disp_d) begin
                rd_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: behavioural raster/framebuffer model feeds expected pixels and writes to queues.
module tb_vga_fb_arbiter;

    logic        FPGA_Clock = 1'b0;
    logic        Reset_N;
    logic [9:0]  H_COUNT;
    logic [9:0]  V_COUNT;
    logic        wr_req;
    logic [16:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic [16:0] fb_addr;
    logic        fb_we;
    logic [7:0]  fb_wdata;
    logic [7:0]  fb_rdata;
    logic [7:0]  R, G, B;
    logic        vblank;

    vga_fb_arbiter dut (
        .FPGA_Clock(FPGA_Clock), .Reset_N(Reset_N), .H_COUNT(H_COUNT), .V_COUNT(V_COUNT),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .fb_addr(fb_addr), .fb_we(fb_we), .fb_wdata(fb_wdata), .fb_rdata(fb_rdata),
        .R(R), .G(G), .B(B), .vblank(vblank)
    );

    always #5 FPGA_Clock = ~FPGA_Clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [31:0] seed;

    always @(posedge FPGA_Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Framebuffer model: untouched cells hold a seeded pattern, writes land in mem.
    bit [7:0] mem [0:131071];
    bit       written [0:131071];

    function automatic logic [7:0] init_val(input int a);
        logic [31:0] x;
        if (a == 0)   return 8'hE0;
        if (a == 321) return 8'h1C;
        x = (32'(a) ^ seed) * 32'h9E3779B1;
        return x[23:16];
    endfunction

    function automatic logic [7:0] ram_val(input int a);
        return written[a] ? mem[a] : init_val(a);
    endfunction

    always @(posedge FPGA_Clock) begin
        if (fb_we) begin
            mem[fb_addr]     <= fb_wdata;
            written[fb_addr] <= 1'b1;
        end
        fb_rdata <= ram_val(int'(fb_addr));
    end

    // Reference: positions encoded as h*1024+v, colour expansion by rounded scaling to 0..255.
    function automatic int succ(input int h, input int v);
        if (h == 799) return (v == 524) ? 0 : v + 1;
        return (h + 1) * 1024 + v;
    endfunction

    function automatic bit fetch_ok(input int h, input int v);
        return (h < 640) && (v < 480) && (h / 2 < 320) && (v / 2 < 240);
    endfunction

    function automatic int fetch_addr(input int h, input int v);
        return (v / 2) * 320 + h / 2;
    endfunction

    function automatic logic [23:0] expand(input logic [7:0] p);
        int r, g, b;
        r = (int'(p[7:5]) * 255 + 3) / 7;
        g = (int'(p[4:2]) * 255 + 3) / 7;
        b = int'(p[1:0]) * 85;
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    function automatic logic [23:0] pixel(input int h, input int v);
        if (!fetch_ok(h, v)) return 24'd0;
        return expand(ram_val(fetch_addr(h, v)));
    endfunction

    typedef struct { int pos; logic [23:0] rgb; } pix_t;
    typedef struct { logic [16:0] a; logic [7:0] d; } wr_t;
    pix_t pix_q[$];
    wr_t  wr_q[$];
    int   cur_h = -1;

    task automatic step(input int h, input int v, input int hold);
        int s;
        H_COUNT = 10'(h);
        V_COUNT = 10'(v);
        while (pix_q.size() > 0 && pix_q[0].pos != h * 1024 + v) void'(pix_q.pop_front());
        if (h != cur_h) begin
            s = succ(h, v);
            pix_q.push_back('{s, pixel(s / 1024, s % 1024)});
        end
        cur_h = h;
        repeat (hold) @(posedge FPGA_Clock);
        #1;
    endtask

    task automatic wr(input logic [16:0] a, input logic [7:0] d, input int maxwait, output int lat);
        int w;
        bit got;
        w = 0;
        got = 0;
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_q.push_back('{a, d});
        while (!got && w <= 20) begin
            @(negedge FPGA_Clock);
            if (wr_ack) got = 1;
            else begin
                w++;
                @(posedge FPGA_Clock);
                #1;
            end
        end
        checks++;
        if (!got || w > maxwait) begin
            errors++;
            $display("FAIL wr_latency: waited %0d cycles (acked=%0d) allowed %0d", w, got, maxwait);
        end
        lat = w;
        if (got) begin
            @(posedge FPGA_Clock);
            #1;
        end
        wr_req = 1'b0;
    endtask

    // Monitor: DISP cycles are recognised from the raster itself.
    logic [9:0] tb_hprev;
    bit         mon_en = 0;
    int         mon_s;
    pix_t       mon_p;
    wr_t        mon_w;

    always @(posedge FPGA_Clock or negedge Reset_N)
        if (!Reset_N) tb_hprev <= '0;
        else          tb_hprev <= H_COUNT;

    always @(negedge FPGA_Clock) begin
        if (mon_en && Reset_N) begin
            if (H_COUNT != tb_hprev) begin
                mon_s = succ(int'(H_COUNT), int'(V_COUNT));
                if (fetch_ok(mon_s / 1024, mon_s % 1024)) begin
                    chk("disp_addr", 32'(fb_addr), 32'(fetch_addr(mon_s / 1024, mon_s % 1024)));
                    chk("disp_no_write", 32'({wr_ack, fb_we}), 32'd0);
                end
                if (pix_q.size() > 0 && pix_q[0].pos == int'(H_COUNT) * 1024 + int'(V_COUNT)) begin
                    mon_p = pix_q.pop_front();
                    chk("pixel_rgb", 32'({R, G, B}), 32'(mon_p.rgb));
                end
            end
            if (fb_we || wr_ack) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h with no request outstanding", fb_addr, fb_wdata);
                end else begin
                    mon_w = wr_q.pop_front();
                    chk("wr_addr", 32'(fb_addr), 32'(mon_w.a));
                    chk("wr_data", 32'(fb_wdata), 32'(mon_w.d));
                    chk("wr_ack_we", 32'({wr_ack, fb_we}), 32'd3);
                end
            end
        end
    end

    initial begin
        int lat;
        int c0;
        bit ok;
        seed    = $urandom;
        Reset_N = 1'b0;
        H_COUNT = '0;
        V_COUNT = 10'd500;
        wr_req  = 1'b1;
        wr_addr = 17'd5;
        wr_data = 8'hAA;

        // Reset holds everything quiet even with a request and a moving raster.
        for (int i = 0; i < 6; i++) begin
            @(posedge FPGA_Clock);
            #1;
            H_COUNT = 10'(i * 37);
            @(negedge FPGA_Clock);
            chk("rst_rgb", 32'({R, G, B}), 32'd0);
            chk("rst_ack", 32'(wr_ack), 32'd0);
            chk("rst_we", 32'(fb_we), 32'd0);
            chk("rst_addr", 32'(fb_addr), 32'd0);
            chk("rst_vblank", 32'(vblank), 32'd0);
        end
        wr_req = 1'b0;
        #2;
        Reset_N = 1'b1;
        mon_en  = 1;
        @(posedge FPGA_Clock);
        #1;

        // Frame wrap: fetch of (0,0) issued while the raster is at 799.
        step(797, 524, 2);
        step(798, 524, 2);
        step(799, 524, 2);
        step(0, 0, 2);
        step(1, 0, 2);
        @(negedge FPGA_Clock);
        chk("vblank_visible", 32'(vblank), 32'd0);
        @(posedge FPGA_Clock);
        #1;

        // Scaling: columns 2 and 3 of line 2 both come from cell 321.
        step(1, 2, 2);
        step(2, 2, 2);
        step(3, 2, 2);
        step(4, 2, 2);

        // Write collides with a DISP read and is acked one cycle later.
        step(9, 10, 2);
        fork
            step(10, 10, 2);
            wr(17'd1234, 8'h03, 1, lat);
        join
        chk("vis_wr_latency", 32'(lat), 32'd1);
        step(11, 10, 2);
        step(12, 10, 2);

        // Blanking: one write per cycle, column 700 is black.
        c0 = cyc;
        fork
            begin
                step(698, 500, 2);
                step(699, 500, 2);
                step(700, 500, 2);
                step(701, 500, 2);
                step(702, 500, 2);
            end
            begin
                for (int i = 0; i < 8; i++) wr(17'(80000 + i * 3), 8'(i * 17 + 1), 0, lat);
                chk("blank_8_writes_cycles", 32'(cyc - c0), 32'd8);
            end
        join
        @(negedge FPGA_Clock);
        chk("vblank_blank", 32'(vblank), 32'd1);
        @(posedge FPGA_Clock);
        #1;

        // Reset right after a DISP read: pending data must never appear.
        step(99, 20, 2);
        step(100, 20, 1);
        Reset_N = 1'b0;
        pix_q.delete();
        #1;
        chk("mid_rst_rgb", 32'({R, G, B}), 32'd0);
        chk("mid_rst_addr", 32'(fb_addr), 32'd0);
        @(negedge FPGA_Clock);
        #2;
        Reset_N = 1'b1;
        @(posedge FPGA_Clock);
        #1;
        fork
            step(101, 20, 2);
            begin
                @(negedge FPGA_Clock);
                ok = ({R, G, B} == 24'd0) || ({R, G, B} == pixel(101, 20));
                chk("post_rst_pixel", 32'(ok), 32'd1);
            end
        join
        step(102, 20, 2);
        step(103, 20, 2);

        // Randomised raster walks with concurrent writes outside the displayed area.
        for (int sg = 0; sg < 8; sg++) begin
            automatic int h;
            automatic int v;
            case (sg)
                0: begin h = 630; v = 100; end
                1: begin h = 780; v = 479; end
                2: begin h = 790; v = 524; end
                3: begin h = 600; v = 477; end
                default: begin h = int'($urandom_range(0, 799)); v = int'($urandom_range(0, 524)); end
            endcase
            fork
                begin
                    for (int k = 0; k < 40; k++) begin
                        automatic int p;
                        step(h, v, int'($urandom_range(2, 4)));
                        p = succ(h, v);
                        h = p / 1024;
                        v = p % 1024;
                    end
                end
                begin
                    for (int k = 0; k < 15; k++) begin
                        automatic int g;
                        automatic int l;
                        g = int'($urandom_range(0, 3));
                        repeat (g) begin
                            @(posedge FPGA_Clock);
                            #1;
                        end
                        wr(17'(76800 + $urandom_range(0, 54271)), 8'($urandom), 1, l);
                    end
                end
            join
        end

        repeat (4) @(posedge FPGA_Clock);
        @(negedge FPGA_Clock);
        chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
